// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential signed/unsigned multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_cond_neg.sv
// Conditional two's-complement negation (wrap-around at W bits).
module mult_cond_neg #(
  parameter int unsigned W = 8
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  always_comb out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/mult_signed_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, sign-magnitude datapath
// with per-operand signed/unsigned mode and valid/ready handshakes.
module mult_signed_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_TERM = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  state_t            state_q;
  logic [WIDTH-1:0]  a_mag_q, b_mag_q;
  logic              neg_q;
  logic [PW-1:0]     acc_q, product_q;
  logic [CW-1:0]     cnt_q;
  logic              in_ready_q, out_valid_q, busy_q;

  logic              a_neg, b_neg, last_iter;
  logic [WIDTH-1:0]  a_abs, b_abs, b_shift;
  logic [PW-1:0]     addend, acc_d, prod_signed;

  assign a_neg = a_signed & a[WIDTH-1];
  assign b_neg = b_signed & b[WIDTH-1];

  mult_cond_neg #(.W(WIDTH)) u_abs_a (.neg_i(a_neg), .in_i(a), .out_o(a_abs));
  mult_cond_neg #(.W(WIDTH)) u_abs_b (.neg_i(b_neg), .in_i(b), .out_o(b_abs));

  // Multiplicand stays put; its weight comes from shifting by the iteration count.
  always_comb begin
    addend    = b_mag_q[0] ? ({{WIDTH{1'b0}}, a_mag_q} << cnt_q) : '0;
    acc_d     = acc_q + addend;
    b_shift   = b_mag_q >> 1;
    last_iter = (cnt_q == CW'(WIDTH - 1)) || (EARLY_TERM && (b_shift == '0));
  end

  mult_cond_neg #(.W(PW)) u_neg_p (.neg_i(neg_q), .in_i(acc_d), .out_o(prod_signed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_mag_q    <= a_abs;
            b_mag_q    <= b_abs;
            neg_q      <= a_neg ^ b_neg;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          b_mag_q <= b_shift;
          cnt_q   <= cnt_q + CW'(1);
          if (last_iter) begin
            product_q   <= prod_signed;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // product_q is deliberately left untouched on release.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mult_signed_seq.sv
// Four multiplier configurations driven in lockstep and checked against an integer a*b model.
module tb_mult_signed_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, a_signed, b_signed, out_ready;
  logic [15:0] a_bus, b_bus;
  logic [3:0]  ir, ov, bz;
  logic [15:0] p0, p1;
  logic [7:0]  p2;
  logic [31:0] p3;
  logic [31:0] pr [4];

  int tests = 0;
  int fails = 0;
  logic [31:0] got [4];
  int          lat [4];

  always #5 clk = ~clk;

  assign pr[0] = {16'b0, p0};
  assign pr[1] = {16'b0, p1};
  assign pr[2] = {24'b0, p2};
  assign pr[3] = p3;

  mult_signed_seq #(.WIDTH(8), .EARLY_TERM(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov[0]), .out_ready(out_ready), .product(p0), .busy(bz[0]));

  mult_signed_seq #(.WIDTH(8), .EARLY_TERM(1'b1)) u_w8e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov[1]), .out_ready(out_ready), .product(p1), .busy(bz[1]));

  mult_signed_seq #(.WIDTH(4), .EARLY_TERM(1'b1)) u_w4e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a_bus[3:0]), .b(b_bus[3:0]), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov[2]), .out_ready(out_ready), .product(p2), .busy(bz[2]));

  mult_signed_seq #(.WIDTH(16), .EARLY_TERM(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .a(a_bus), .b(b_bus), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov[3]), .out_ready(out_ready), .product(p3), .busy(bz[3]));

  function automatic int unsigned wid(input int i);
    case (i)
      0, 1:    return 8;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic bit et(input int i);
    return (i == 1) || (i == 2);
  endfunction

  // Operand value as an integer, interpreted at width w.
  function automatic longint sval(input int unsigned w, input logic [15:0] v, input bit sgn);
    longint x;
    x = longint'(v) & ((64'sd1 <<< w) - 64'sd1);
    if (sgn && x[w-1]) x = x - (64'sd1 <<< w);
    return x;
  endfunction

  function automatic logic [31:0] exp_prod(input int i);
    int unsigned w;
    longint p;
    w = wid(i);
    p = sval(w, a_bus, a_signed) * sval(w, b_bus, b_signed);
    return 32'(p & ((64'sd1 <<< (2 * w)) - 64'sd1));
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int exp_lat(input int i);
    int unsigned w;
    longint m;
    int n;
    w = wid(i);
    if (!et(i)) return int'(w) + 1;
    m = sval(w, b_bus, b_signed);
    if (m < 0) m = -m;
    n = 0;
    while (m > 0) begin
      n++;
      m = m >>> 1;
    end
    return ((n == 0) ? 1 : n) + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (a=%h b=%h as=%0b bs=%0b)",
               name, act, exp, a_bus, b_bus, a_signed, b_signed);
    end
  endtask

  // Called just after the accept edge; leaves the bench at a negedge with every unit idle.
  task automatic collect(input string name);
    bit seen [4];
    int nseen;
    nseen = 0;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    for (int k = 1; k <= 40 && nseen < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
          check($sformatf("%s u%0d in_ready in CALC", name, i), 32'(ir[i]), 32'd0);
          check($sformatf("%s u%0d busy in CALC", name, i), 32'(bz[i]), 32'd1);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && ov[i]) begin
          seen[i] = 1'b1;
          nseen++;
          lat[i] = k;
          got[i] = pr[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!seen[i]) begin
        check($sformatf("%s u%0d out_valid timeout", name, i), 32'd0, 32'd1);
        got[i] = 'x;
        lat[i] = -1;
      end else begin
        check($sformatf("%s u%0d product", name, i), got[i], exp_prod(i));
        check($sformatf("%s u%0d latency", name, i), 32'(lat[i]), 32'(exp_lat(i)));
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [15:0] av, input logic [15:0] bv,
                     input bit as, input bit bs);
    a_bus = av; b_bus = bv; a_signed = as; b_signed = bs;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    collect(name);
  endtask

  typedef struct {
    logic [7:0]  a, b;
    bit          as, bs;
    logic [15:0] prod;
    int          lat0, lat1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int k;

    tbl[0] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, 9, 9};
    tbl[1] = '{8'h80, 8'h01, 1'b1, 1'b1, 16'hFF80, 9, 2};
    tbl[2] = '{8'h7F, 8'hFF, 1'b1, 1'b1, 16'hFF81, 9, 2};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 9, 9};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01, 9, 9};
    tbl[5] = '{8'h05, 8'h00, 1'b1, 1'b1, 16'h0000, 9, 2};
    tbl[6] = '{8'h07, 8'h03, 1'b1, 1'b1, 16'h0015, 9, 3};
    tbl[7] = '{8'h01, 8'h80, 1'b0, 1'b0, 16'h0080, 9, 9};
    tbl[8] = '{8'h01, 8'h80, 1'b1, 1'b1, 16'hFF80, 9, 9};
    tbl[9] = '{8'h03, 8'hFB, 1'b1, 1'b1, 16'hFFF1, 9, 4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_bus = '0; b_bus = '0; a_signed = 1'b0; b_signed = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset u%0d in_ready", i), 32'(ir[i]), 32'd1);
      check($sformatf("reset u%0d out_valid", i), 32'(ov[i]), 32'd0);
      check($sformatf("reset u%0d busy", i), 32'(bz[i]), 32'd0);
      check($sformatf("reset u%0d product", i), pr[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      run($sformatf("vec%0d", t), {8'h00, tbl[t].a}, {8'h00, tbl[t].b}, tbl[t].as, tbl[t].bs);
      check($sformatf("vec%0d w8 product", t), got[0], 32'(tbl[t].prod));
      check($sformatf("vec%0d w8 latency", t), 32'(lat[0]), 32'(tbl[t].lat0));
      check($sformatf("vec%0d w8e product", t), got[1], 32'(tbl[t].prod));
      check($sformatf("vec%0d w8e latency", t), 32'(lat[1]), 32'(tbl[t].lat1));
    end

    // Backpressure: result held, second request waits for release plus one cycle.
    a_bus = 16'd3; b_bus = 16'd4; a_signed = 1'b1; b_signed = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_bus = 16'd5; b_bus = 16'd6;
    check("bp in_ready while busy", 32'(ir[0]), 32'd0);
    k = 0;
    while (ov != 4'hF && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp all out_valid", 32'(ov), 32'hF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d product", c), pr[0], 32'd12);
      check($sformatf("bp hold%0d out_valid", c), 32'(ov[0]), 32'd1);
      check($sformatf("bp hold%0d in_ready", c), 32'(ir[0]), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 32'(ov[0]), 32'd0);
    check("bp release in_ready", 32'(ir[0]), 32'd1);
    check("bp release product held", pr[0], 32'd12);
    @(posedge clk);
    collect("bp second");
    check("bp second w8 product", got[0], 32'd30);

    // Reset during the fourth CALC cycle.
    a_bus = 16'h007F; b_bus = 16'h007F; a_signed = 1'b1; b_signed = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst calc busy before", 32'(bz[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst calc u%0d out_valid", i), 32'(ov[i]), 32'd0);
      check($sformatf("rst calc u%0d busy", i), 32'(bz[i]), 32'd0);
      check($sformatf("rst calc u%0d product", i), pr[i], 32'd0);
      check($sformatf("rst calc u%0d in_ready", i), 32'(ir[i]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a result is pending in DONE.
    a_bus = 16'd3; b_bus = 16'd4; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (ov != 4'hF && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst done out_valid before", 32'(ov), 32'hF);
    rst_n = 1'b0;
    #1;
    check("rst done out_valid", 32'(ov), 32'h0);
    check("rst done w8 product", pr[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    run("after rst", 16'h0003, 16'h00FB, 1'b1, 1'b1);
    check("after rst w8 product", got[0], 32'h0000FFF1);

    // Exhaustive at WIDTH=4 (all modes); upper bits randomised for the wider units.
    for (int m = 0; m < 4; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          r = $urandom;
          run("exh", {r[15:4], 4'(x)}, {r[31:20], 4'(y)}, m[0], m[1]);
        end
      end
    end

    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      run("rnd", r[15:0], r[31:16], 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
